alu8_arbiter_ctrl: RTL and testbench

//  Arbitrates two requesters for one shared combinational 8-bit ALU (4-bit Op, 8-bit result,
//  16-bit product, OF/zero/slt flags). Accepts one command per handshake, drives the ALU from

---
 rtl/alu8_arbiter_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu8_arbiter_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_arbiter_ctrl.sv
// Two-requester arbiter and sequencer for a shared external 8-bit ALU.
// Define ARB_FIXED_PRIO_EN to make req0 win every tie (default: round-robin tie-break).
module alu8_arbiter_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    output logic [3:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_result,
    input  logic [15:0]      alu_product,
    input  logic             alu_of,
    input  logic             alu_zero,
    input  logic             alu_slt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic [15:0]      rsp_product,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] OP_MUL    = 4'd11;
    localparam logic [3:0] MUL_CYCLES = 4'(MUL_LAT);

    logic [1:0] state;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic [3:0] sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic       sel_illegal;
    logic [3:0] op_q;
    logic       id_q;
    logic       illegal_q;
    logic [3:0] exec_cnt;
    logic [3:0] exec_lat;
    logic       exec_done;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant = 1'b0;
        if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant;
`endif
        end
    end

    assign req0_ready = (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready = (state == S_IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != S_IDLE);

    assign sel_op      = grant ? req1_op : req0_op;
    assign sel_a       = grant ? req1_a  : req0_a;
    assign sel_b       = grant ? req1_b  : req0_b;
    assign sel_illegal = (sel_op >= 4'd12) && (sel_op <= 4'd14);

    // Only a multiply holds EXEC for more than one cycle; illegal ops never match OP_MUL.
    assign exec_lat  = (op_q == OP_MUL) ? MUL_CYCLES : 4'd1;
    assign exec_done = (exec_cnt == exec_lat - 4'd1);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            op_q        <= '0;
            id_q        <= 1'b0;
            illegal_q   <= 1'b0;
            exec_cnt    <= '0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_product <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
            done_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= sel_op;
                        id_q       <= grant;
                        illegal_q  <= sel_illegal;
                        last_grant <= grant;
                        exec_cnt   <= '0;
                        // The ALU bus is left untouched for illegal ops so it never toggles needlessly.
                        if (!sel_illegal) begin
                            alu_op <= sel_op;
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                        end
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_err   <= illegal_q;
                        if (illegal_q) begin
                            rsp_result  <= '0;
                            rsp_product <= '0;
                            rsp_flags   <= '0;
                        end else begin
                            rsp_result  <= alu_result;
                            rsp_product <= (op_q == OP_MUL) ? alu_product : 16'd0;
                            rsp_flags   <= {alu_of, alu_zero, alu_slt};
                        end
                        state <= S_RESP;
                    end else begin
                        exec_cnt <= exec_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu8_arbiter_ctrl.sv
// Directed bench for alu8_arbiter_ctrl with a small behavioural ALU standing in for the real one.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu8_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [7:0]  alu_result;
    logic [15:0] alu_product;
    logic        alu_of, alu_zero, alu_slt;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0]  rsp_result;
    logic [15:0] rsp_product;
    logic [2:0]  rsp_flags;
    logic [15:0] done_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu8_arbiter_ctrl #(.MUL_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_product(alu_product),
        .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_product(rsp_product), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
    );

    // Stand-in ALU: 1=AND, 9=ADD, 11=MUL, anything else XOR; product is always a*b.
    always_comb begin
        logic [8:0] sum;
        sum         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_product = 16'(alu_a) * 16'(alu_b);
        alu_of      = 1'b0;
        case (alu_op)
            4'd1:  alu_result = alu_a & alu_b;
            4'd9: begin
                alu_result = sum[7:0];
                alu_of     = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
            end
            4'd11: begin
                alu_result = alu_product[7:0];
                alu_of     = |alu_product[15:8];
            end
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == 8'd0);
        alu_slt  = $signed(alu_a) < $signed(alu_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advances falling edges until rsp_valid, counting edges from the request edge.
    task automatic wait_rsp(input bit drop, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop && n == 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end while (!rsp_valid && n < 20);
    endtask

    initial begin
        int n;
        int last_acc;
        int d0;
        logic exp_id;

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy",     32'(busy),      32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_done_cnt", 32'(done_cnt),  32'd0);
        check("reset_alu_op",   32'(alu_op),    32'd0);
        check("reset_ready0",   32'(req0_ready), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);

        // AND from req0, stepped one edge at a time
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 8'hCC; req0_b = 8'hAA;
        #1;
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        check("t1_exec_busy",  32'(busy),      32'd1);
        check("t1_exec_alu_op", 32'(alu_op),   32'd1);
        check("t1_exec_alu_a", 32'(alu_a),     32'hCC);
        check("t1_exec_alu_b", 32'(alu_b),     32'hAA);
        check("t1_exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_rsp_valid",  32'(rsp_valid),  32'd1);
        check("t1_rsp_result", 32'(rsp_result), 32'h88);
        check("t1_rsp_id",     32'(rsp_id),     32'd0);
        check("t1_rsp_err",    32'(rsp_err),    32'd0);
        check("t1_rsp_product", 32'(rsp_product), 32'd0);
        check("t1_rsp_flags",  32'(rsp_flags),  32'b000);
        @(negedge clk);
        check("t1_after_valid", 32'(rsp_valid), 32'd0);
        check("t1_after_done",  32'(done_cnt),  32'd1);
        check("t1_after_busy",  32'(busy),      32'd0);

        // Both requesters valid continuously: ties alternate starting at req0 after reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd9; req0_a = 8'h0F; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 4'd9; req1_a = 8'h0F; req1_b = 8'h01;
        last_acc = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("t2_ready0", 32'(req0_ready), 32'(!exp_id));
            check("t2_ready1", 32'(req1_ready), 32'(exp_id));
            if (i > 0) check("t2_spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            wait_rsp(i == 3, n);
            check("t2_latency", 32'(n), 32'd2);
            check("t2_rsp_id", 32'(rsp_id), 32'(exp_id));
            check("t2_rsp_result", 32'(rsp_result), 32'h10);
        end
        @(negedge clk);
        check("t2_done_cnt", 32'(done_cnt), 32'd4);

        // Multiply from req1: three edges from request to response
        req1_valid = 1'b1; req1_op = 4'd11; req1_a = 8'h03; req1_b = 8'h05;
        #1;
        check("t3_ready1", 32'(req1_ready), 32'd1);
        wait_rsp(1'b1, n);
        check("t3_latency",     32'(n),           32'd3);
        check("t3_rsp_product", 32'(rsp_product), 32'h000F);
        check("t3_rsp_result",  32'(rsp_result),  32'h0F);
        check("t3_rsp_id",      32'(rsp_id),      32'd1);
        check("t3_rsp_flags",   32'(rsp_flags),   32'b001);
        check("t3_alu_op",      32'(alu_op),      32'd11);
        @(negedge clk);

        // Illegal op 13: error response, ALU bus keeps the multiply operands
        req0_valid = 1'b1; req0_op = 4'd13; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        check("t4_ready0", 32'(req0_ready), 32'd1);
        wait_rsp(1'b1, n);
        check("t4_latency",     32'(n),           32'd2);
        check("t4_rsp_err",     32'(rsp_err),     32'd1);
        check("t4_rsp_result",  32'(rsp_result),  32'd0);
        check("t4_rsp_product", 32'(rsp_product), 32'd0);
        check("t4_rsp_flags",   32'(rsp_flags),   32'd0);
        check("t4_alu_op",      32'(alu_op),      32'd11);
        check("t4_alu_a",       32'(alu_a),       32'h03);
        @(negedge clk);

        // Consumer stalls for five cycles while req1 waits
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd9; req0_a = 8'h7F; req0_b = 8'h01;
        #1;
        wait_rsp(1'b1, n);
        check("t5_rsp_result", 32'(rsp_result), 32'h80);
        check("t5_rsp_flags",  32'(rsp_flags),  32'b100);
        check("t5_rsp_err",    32'(rsp_err),    32'd0);
        d0 = 32'(done_cnt);
        req1_valid = 1'b1; req1_op = 4'd9; req1_a = 8'h01; req1_b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid",  32'(rsp_valid),  32'd1);
            check("t5_hold_result", 32'(rsp_result), 32'h80);
            check("t5_hold_id",     32'(rsp_id),     32'd0);
            check("t5_hold_ready1", 32'(req1_ready), 32'd0);
            check("t5_hold_done",   32'(done_cnt),   32'(d0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t5_release_valid", 32'(rsp_valid),  32'd0);
        check("t5_release_done",  32'(done_cnt),   32'(d0 + 1));
        check("t5_waiting_ready1", 32'(req1_ready), 32'd1);
        wait_rsp(1'b1, n);
        check("t5b_latency", 32'(n),          32'd2);
        check("t5b_rsp_id",  32'(rsp_id),     32'd1);
        check("t5b_result",  32'(rsp_result), 32'h02);
        @(negedge clk);
        check("t5b_done", 32'(done_cnt), 32'(d0 + 2));

        // Reset in the middle of a multiply discards it
        req1_valid = 1'b1; req1_op = 4'd11; req1_a = 8'h03; req1_b = 8'h05;
        @(negedge clk);
        req1_valid = 1'b0;
        check("t6_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_busy",      32'(busy),      32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_done_cnt",  32'(done_cnt),  32'd0);
        check("t6_alu_op",    32'(alu_op),    32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 8'hF0; req0_b = 8'h3C;
        #1;
        check("t6_fresh_ready0", 32'(req0_ready), 32'd1);
        wait_rsp(1'b1, n);
        check("t6_fresh_latency", 32'(n),          32'd2);
        check("t6_fresh_result",  32'(rsp_result), 32'h30);
        check("t6_fresh_flags",   32'(rsp_flags),  32'b001);
        check("t6_fresh_id",      32'(rsp_id),     32'd0);
        @(negedge clk);
        check("t6_fresh_done", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
